// File: rtl/aud_recorder.sv
// aud_recorder: I2S ADC capture path.
// Deserialises codec ADCDAT (MSB first, one BCLK after the LRCK edge) into DATA_W-bit words.
// Each completed word produces a one-cycle write strobe with its address and data for the
// SRAM controller. The block is started, paused and stopped by the top-level FSM.
//
// Build option: define AUD_REC_STEREO_EN to also capture the right channel. Words are then
// interleaved L,R at consecutive addresses, and a recording always begins on a left word.
// Without the macro only the left channel is captured.
//
// Ports:
//   i_bclk     codec bit clock; all logic runs on its rising edge
//   i_rst_n    asynchronous active-low reset
//   i_lrc      codec ADCLRCK (0 = left channel)
//   i_adcdat   codec serial ADC data
//   i_start    level: start from idle, or resume from pause
//   i_pause    level: pause at the next word boundary
//   i_stop     level: abort and return to idle
//   o_address  address of the word on o_data
//   o_data     captured word
//   o_valid    one-cycle write strobe
//   o_full     memory full; sticky until the next start from idle
//   o_rec_len  words written since the last start from idle
module aud_recorder #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic [ADDR_W:0]   o_rec_len
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StWait, StCapture, StSave, StPause} state_e;

  state_e              state_q, state_d;
  logic                lrc_q;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                full_q, full_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic                pause_req_q, pause_req_d;

  logic fall, rise, start_edge;

  assign fall = lrc_q & ~i_lrc;
  assign rise = ~lrc_q & i_lrc;

`ifdef AUD_REC_STEREO_EN
  logic ch_q, ch_d;                  // channel of the word being captured, 1 = right
  logic want_right_q, want_right_d;  // next word to capture is the right channel
  assign start_edge = want_right_q ? rise : fall;
`else
  assign start_edge = fall;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_addr_d   = wr_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    full_d      = full_q;
    rec_len_d   = rec_len_q;
    pause_req_d = pause_req_q;
`ifdef AUD_REC_STEREO_EN
    ch_d         = ch_q;
    want_right_d = want_right_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          state_d   = StWait;
          wr_addr_d = '0;
          rec_len_d = '0;
          full_d    = 1'b0;
`ifdef AUD_REC_STEREO_EN
          want_right_d = 1'b0;
`endif
        end
      end

      StWait: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_pause) begin
          state_d = StPause;
        end else if (start_edge) begin
          // The edge that detects LRCK does not sample: I2S puts the MSB one BCLK later.
          state_d     = StCapture;
          bit_cnt_d   = '0;
          pause_req_d = 1'b0;
`ifdef AUD_REC_STEREO_EN
          ch_d = want_right_q;
`endif
        end
      end

      StCapture: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if ((fall || rise) && (bit_cnt_q != LastBit)) begin
          // Short slot: drop the partial word and resynchronise.
          state_d = StWait;
        end else begin
          shift_d   = {shift_q[DATA_W-2:0], i_adcdat};
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Remember a pause request so it takes effect after this word is written.
          if (i_pause) pause_req_d = 1'b1;
          if (bit_cnt_q == LastBit) state_d = StSave;
        end
      end

      StSave: begin
        if (i_stop) begin
          state_d = StIdle;
        end else begin
          valid_d   = 1'b1;
          data_d    = shift_q;
          addr_d    = wr_addr_q;
          rec_len_d = rec_len_q + 1'b1;
`ifdef AUD_REC_STEREO_EN
          want_right_d = ~ch_q;
`endif
          if (wr_addr_q == MAX_ADDR) begin
            full_d  = 1'b1;
            state_d = StIdle;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = (i_pause || pause_req_q) ? StPause : StWait;
          end
        end
      end

      StPause: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_start && !i_pause) begin
          state_d = StWait;
`ifdef AUD_REC_STEREO_EN
          want_right_d = 1'b0;  // resume on a left word
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      lrc_q       <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_addr_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
      rec_len_q   <= '0;
      pause_req_q <= 1'b0;
`ifdef AUD_REC_STEREO_EN
      ch_q         <= 1'b0;
      want_right_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lrc_q       <= i_lrc;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_addr_q   <= wr_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      full_q      <= full_d;
      rec_len_q   <= rec_len_d;
      pause_req_q <= pause_req_d;
`ifdef AUD_REC_STEREO_EN
      ch_q         <= ch_d;
      want_right_q <= want_right_d;
`endif
    end
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_full    = full_q;
  assign o_rec_len = rec_len_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Testbench for aud_recorder: drives 64-BCLK I2S frames (32-BCLK slots) with control events,
// and compares every write strobe and status output against a frame-level reference model.
module tb_aud_recorder;
  localparam int unsigned       DATA_W   = 16;
  localparam int unsigned       ADDR_W   = 20;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 20'd3;
  localparam int                MaxWords = 4;
`ifdef AUD_REC_STEREO_EN
  localparam bit Stereo = 1'b1;
`else
  localparam bit Stereo = 1'b0;
`endif

  // Frame event kinds.
  localparam int KNone = 0, KPauseL = 1, KStopL = 2, KStart = 3;
  localparam int KResume = 4, KPauseR = 5, KStopR = 6, KReset = 7;
  // Model recorder states.
  localparam int SIdle = 0, SRec = 1, SPause = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_lrc = 1'b1;
  logic              i_adcdat = 1'b0;
  logic              i_start = 1'b0;
  logic              i_pause = 1'b0;
  logic              i_stop = 1'b0;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_full;
  logic [ADDR_W:0]   o_rec_len;

  aud_recorder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_ADDR(MAX_ADDR)
  ) dut (
    .i_bclk   (clk),
    .i_rst_n  (rst_n),
    .i_lrc    (i_lrc),
    .i_adcdat (i_adcdat),
    .i_start  (i_start),
    .i_pause  (i_pause),
    .i_stop   (i_stop),
    .o_address(o_address),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_rec_len(o_rec_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   len;
    int                cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (o_valid) obs_q.push_back('{addr: o_address, data: o_data, len: o_rec_len, cyc: cyc});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int                st = SIdle;
  int                n = 0;
  bit                full = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;

  task automatic push_write(input logic [DATA_W-1:0] d, input int at);
    exp_q.push_back('{addr: ADDR_W'(n), data: d, len: (ADDR_W + 1)'(n + 1), cyc: at});
    last_addr = ADDR_W'(n);
    last_data = d;
    if (n == MaxWords - 1) begin
      full = 1'b1;
      st   = SIdle;
    end
    n++;
  endtask

  task automatic model_frame(input int kind, input logic [DATA_W-1:0] l, r, input int e0);
    if (kind == KReset) begin
      st = SIdle; n = 0; full = 1'b0; last_addr = '0; last_data = '0;
      return;
    end
    if (kind == KStopL) begin
      st = SIdle;
    end else if (st == SRec) begin
      // Left word: MSB one BCLK after the fall, strobe 17 BCLK after it.
      push_write(l, e0 + 17);
      if (st == SRec && kind == KPauseL) st = SPause;
      if (Stereo && st == SRec) push_write(r, e0 + 49);
    end
    case (kind)
      KStart:  if (st == SIdle) begin st = SRec; n = 0; full = 1'b0; end
      KResume: if (st == SPause) st = SRec;
      KPauseR: if (st == SRec) st = SPause;
      KStopR:  st = SIdle;
      default: ;
    endcase
  endtask

  task automatic run_frame(input int kind, input int slot, input logic [DATA_W-1:0] l, r,
                           output int e0);
    e0 = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      i_start = 1'b0;
      i_stop  = 1'b0;
      i_lrc   = (i >= 32);
      if (i >= 1 && i <= 16) i_adcdat = l[16-i];
      else if (i >= 33 && i <= 48) i_adcdat = r[48-i];
      else i_adcdat = 1'($urandom);
      if (i == slot) begin
        case (kind)
          KPauseL, KPauseR: i_pause = 1'b1;
          KStopL, KStopR: begin i_stop = 1'b1; i_pause = 1'b0; end
          KStart, KResume: begin i_start = 1'b1; i_pause = 1'b0; end
          KReset: begin
            rst_n   = 1'b0;
            i_pause = 1'b0;
            #1;
            check_eq("rst_mid_valid", 32'(o_valid), 32'd0);
            check_eq("rst_mid_data", 32'(o_data), 32'd0);
            check_eq("rst_mid_addr", 32'(o_address), 32'd0);
            check_eq("rst_mid_len", 32'(o_rec_len), 32'd0);
            check_eq("rst_mid_full", 32'(o_full), 32'd0);
          end
          default: ;
        endcase
      end
      if (kind == KReset && i == slot + 2) rst_n = 1'b1;
    end
  endtask

  task automatic do_frame(input int kind, input int slot, input logic [DATA_W-1:0] l, r);
    int e0;
    int m;
    run_frame(kind, slot, l, r, e0);
    model_frame(kind, l, r, e0);
    check_eq("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq("wr_addr", 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check_eq("wr_data", 32'(obs_q[i].data), 32'(exp_q[i].data));
      check_eq("wr_len", 32'(obs_q[i].len), 32'(exp_q[i].len));
      check_eq("wr_cycle", 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
    end
    obs_q.delete();
    exp_q.delete();
    check_eq("rec_len", 32'(o_rec_len), 32'(n));
    check_eq("full", 32'(o_full), 32'(full));
    check_eq("valid_idle", 32'(o_valid), 32'd0);
    check_eq("addr_hold", 32'(o_address), 32'(last_addr));
    check_eq("data_hold", 32'(o_data), 32'(last_data));
  endtask

  initial begin
    int k, s, p;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_addr", 32'(o_address), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_len", 32'(o_rec_len), 32'd0);
    check_eq("rst_full", 32'(o_full), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed sequence.
    do_frame(KStart, 52, 16'hDEAD, 16'h5A5A);
    do_frame(KNone, -1, 16'hA5C3, 16'h3C3C);
    do_frame(KStopL, 9, 16'hBEEF, 16'h1111);
    do_frame(KStart, 55, 16'hC0DE, 16'h2222);
    do_frame(KNone, -1, 16'h0001, 16'hFFFF);
    do_frame(KNone, -1, 16'h8000, 16'h0000);
    do_frame(KPauseL, 8, 16'hFFFF, 16'h1234);
    do_frame(KNone, -1, 16'h7777, 16'h8888);
    do_frame(KResume, 56, 16'h6666, 16'h9999);
    do_frame(KNone, -1, 16'h1234, 16'hABCD);
    do_frame(KNone, -1, 16'h1357, 16'h2468);
    do_frame(KNone, -1, 16'h2468, 16'h1357);
    do_frame(KReset, 10, 16'hFACE, 16'h0F0F);
    do_frame(KStart, 53, 16'h4444, 16'h5555);
    do_frame(KNone, -1, 16'h0F0F, 16'hF0F0);

    // Randomised sequence, event choice driven by the model's current state.
    for (int f = 0; f < 50; f++) begin
      p = $urandom_range(99);
      case (st)
        SIdle:   k = (p < 70) ? KStart : KNone;
        SRec:    k = (p < 12) ? KPauseL : (p < 22) ? KStopL : (p < 32) ? KPauseR :
                     (p < 37) ? KStopR : (p < 41) ? KReset : KNone;
        default: k = (p < 60) ? KResume : (p < 70) ? KStopR : KNone;
      endcase
      s = (k == KPauseL || k == KStopL || k == KReset) ? $urandom_range(15, 2)
                                                       : $urandom_range(60, 52);
      do_frame(k, s, 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
